// File: rtl/ofdm_symbol_scheduler.sv
// Per-symbol subcarrier sequencer for the 802.11a IFFT feed: null/pilot/data decode,
// interleaver reads, pilot polarity scrambling. Optional stall counter: SCHED_STALL_CNT_EN.
module ofdm_symbol_scheduler #(
    parameter int unsigned SYM_W      = 12,
    parameter logic [6:0]  PILOT_SEED = 7'h7F
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [SYM_W-1:0] num_symbols_i,
    input  logic             full_intlver_i,
    output logic             clear_intlver_o,
    output logic             rd_en_intlver_o,
    output logic [5:0]       rd_addr_intlver_o,
    output logic             ostream_val_o,
    input  logic             ostream_rdy_i,
    output logic [5:0]       sc_index_o,
    output logic             is_zero_o,
    output logic             is_pilot_o,
    output logic             pilot_indicator_o,
    output logic [SYM_W-1:0] symbol_cnt_o,
    output logic             busy_o,
    output logic             done_o
`ifdef SCHED_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cycles_o
`endif
);

    typedef enum logic [1:0] {StIdle, StWaitFull, StStream, StDone} state_e;

    state_e           state_q, state_d;
    logic [5:0]       sc_q, sc_d;
    logic [SYM_W-1:0] sym_q, sym_d;
    logic [SYM_W-1:0] num_q, num_d;
    logic [6:0]       scr_q, scr_d;
    logic             val_q, val_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fire;
    logic             last_sc;
    logic             pol;
    logic             null_bin;
    logic             pilot_bin;
    logic [5:0]       addr;
    logic [SYM_W-1:0] sym_inc;

    assign fire    = val_q & ostream_rdy_i;
    assign last_sc = (sc_q == 6'd63);
    assign pol     = scr_q[6] ^ scr_q[3];
    assign sym_inc = sym_q + {{(SYM_W-1){1'b0}}, 1'b1};

    // Bin classification and interleaver address: data bins ordered by frequency -26..+26.
    always_comb begin
        null_bin  = (sc_q == 6'd0) || ((sc_q >= 6'd27) && (sc_q <= 6'd37));
        pilot_bin = (sc_q == 6'd7) || (sc_q == 6'd21) || (sc_q == 6'd43) || (sc_q == 6'd57);
        addr      = 6'd0;
        if ((sc_q >= 6'd1) && (sc_q <= 6'd6)) begin
            addr = sc_q + 6'd23;
        end else if ((sc_q >= 6'd8) && (sc_q <= 6'd20)) begin
            addr = sc_q + 6'd22;
        end else if ((sc_q >= 6'd22) && (sc_q <= 6'd26)) begin
            addr = sc_q + 6'd21;
        end else if ((sc_q >= 6'd38) && (sc_q <= 6'd42)) begin
            addr = sc_q - 6'd38;
        end else if ((sc_q >= 6'd44) && (sc_q <= 6'd56)) begin
            addr = sc_q - 6'd39;
        end else if (sc_q >= 6'd58) begin
            addr = sc_q - 6'd40;
        end
    end

    always_comb begin
        state_d = state_q;
        sc_d    = sc_q;
        sym_d   = sym_q;
        num_d   = num_q;
        scr_d   = scr_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    num_d   = num_symbols_i;
                    sym_d   = '0;
                    sc_d    = 6'd0;
                    scr_d   = PILOT_SEED;
                    state_d = (num_symbols_i == '0) ? StDone : StWaitFull;
                end
            end
            StWaitFull: begin
                if (full_intlver_i) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                if (fire) begin
                    sc_d = sc_q + 6'd1;
                    if (last_sc) begin
                        scr_d   = {scr_q[5:0], pol};
                        sym_d   = sym_inc;
                        state_d = (sym_inc == num_q) ? StDone : StWaitFull;
                    end
                end
            end
            StDone: begin
                sym_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        val_d  = (state_d == StStream);
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            sc_q    <= 6'd0;
            sym_q   <= '0;
            num_q   <= '0;
            scr_q   <= PILOT_SEED;
            val_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            sym_q   <= sym_d;
            num_q   <= num_d;
            scr_q   <= scr_d;
            val_q   <= val_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ostream_val_o     = val_q;
    assign sc_index_o        = sc_q;
    assign is_zero_o         = val_q & null_bin;
    assign is_pilot_o        = val_q & pilot_bin;
    // Bin 21 carries a -1 base value, so its polarity is inverted against the others.
    assign pilot_indicator_o = ~(pol ^ (sc_q == 6'd21));
    assign rd_en_intlver_o   = fire & ~null_bin & ~pilot_bin;
    assign rd_addr_intlver_o = addr;
    assign clear_intlver_o   = fire & last_sc;
    assign symbol_cnt_o      = sym_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;

`ifdef SCHED_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == StIdle) && start_i) begin
            stall_d = 16'd0;
        end else if (val_q && !ostream_rdy_i && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_ofdm_symbol_scheduler.sv
// Scoreboard bench for ofdm_symbol_scheduler: directed frames push expected beats,
// a negedge monitor pops and compares every accepted subcarrier.
module tb_ofdm_symbol_scheduler;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] num_symbols;
    logic        full;
    logic        clear;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic        val;
    logic        rdy;
    logic [5:0]  sc;
    logic        is_zero;
    logic        is_pilot;
    logic        pind;
    logic [11:0] symcnt;
    logic        busy;
    logic        done;
`ifdef SCHED_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    ofdm_symbol_scheduler #(
        .SYM_W      (12),
        .PILOT_SEED (7'h7F)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .start_i           (start),
        .num_symbols_i     (num_symbols),
        .full_intlver_i    (full),
        .clear_intlver_o   (clear),
        .rd_en_intlver_o   (rd_en),
        .rd_addr_intlver_o (rd_addr),
        .ostream_val_o     (val),
        .ostream_rdy_i     (rdy),
        .sc_index_o        (sc),
        .is_zero_o         (is_zero),
        .is_pilot_o        (is_pilot),
        .pilot_indicator_o (pind),
        .symbol_cnt_o      (symcnt),
        .busy_o            (busy),
        .done_o            (done)
`ifdef SCHED_STALL_CNT_EN
        ,
        .stall_cycles_o    (stall_cycles)
`endif
    );

    typedef struct packed {
        logic [5:0]  sc;
        logic        zero;
        logic        pilot;
        logic        pind;
        logic        rden;
        logic [5:0]  addr;
        logic        clr;
        logic [11:0] sym;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    beats    = 0;
    int    rd_cnt   = 0;
    int    rd32_cnt = 0;
    int    clear_cyc = -1;
    int    addr_tab[64];
    // Pilot polarity bit per symbol from seed 7F: 0,0,0,0,1.
    bit    pol_tab[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input int nsym);
        beat_t e;
        for (int s = 0; s < nsym; s++) begin
            for (int k = 0; k < 64; k++) begin
                e.sc    = 6'(k);
                e.zero  = (k == 0) || (k >= 27 && k <= 37);
                e.pilot = (k == 7) || (k == 21) || (k == 43) || (k == 57);
                e.pind  = (k == 21) ? pol_tab[s % 5] : ~pol_tab[s % 5];
                e.rden  = !e.zero && !e.pilot;
                e.addr  = e.rden ? 6'(addr_tab[k]) : 6'd0;
                e.clr   = (k == 63);
                e.sym   = 12'(s);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic start_frame(input int n);
        @(posedge clk); #1;
        num_symbols = 12'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, output int dcyc);
        int n = 0;
        while (!done && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        dcyc = cyc;
        chk({nm, "_done_seen"}, 32'(n < 2000), 1);
    endtask

    task automatic wait_beat(input int k, input int s, input string nm);
        int n = 0;
        while (!(val && sc == 6'(k) && symcnt == 12'(s)) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_reached"}, 32'(n < 2000), 1);
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_val"}, 32'(val), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_done"}, 32'(done), 0);
        chk({nm, "_clear"}, 32'(clear), 0);
        chk({nm, "_rd_en"}, 32'(rd_en), 0);
        chk({nm, "_rd_addr"}, 32'(rd_addr), 0);
        chk({nm, "_sc"}, 32'(sc), 0);
        chk({nm, "_is_zero"}, 32'(is_zero), 0);
        chk({nm, "_is_pilot"}, 32'(is_pilot), 0);
        chk({nm, "_pind"}, 32'(pind), 1);
        chk({nm, "_symcnt"}, 32'(symcnt), 0);
    endtask

    task automatic after_done(input string nm, input int dcyc);
        chk({nm, "_done_latency"}, 32'(dcyc), 32'(clear_cyc + 1));
        chk({nm, "_queue_drained"}, 32'(exp_q.size()), 0);
        @(posedge clk); #1;
        chk({nm, "_busy_after"}, 32'(busy), 0);
        chk({nm, "_done_one_cycle"}, 32'(done), 0);
    endtask

    // Monitor: compare every accepted beat against the queue head.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n) begin
            if (val && !rdy) begin
                chk("stall_rd_en", 32'(rd_en), 0);
                if (exp_q.size() > 0) chk("stall_sc_hold", 32'(sc), 32'(exp_q[0].sc));
            end else if (val) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat_sc", 32'(sc), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    beats++;
                    chk("beat_sc", 32'(sc), 32'(e.sc));
                    chk("beat_is_zero", 32'(is_zero), 32'(e.zero));
                    chk("beat_is_pilot", 32'(is_pilot), 32'(e.pilot));
                    if (e.pilot) chk("beat_pilot_ind", 32'(pind), 32'(e.pind));
                    chk("beat_rd_en", 32'(rd_en), 32'(e.rden));
                    chk("beat_rd_addr", 32'(rd_addr), 32'(e.addr));
                    chk("beat_clear", 32'(clear), 32'(e.clr));
                    chk("beat_symcnt", 32'(symcnt), 32'(e.sym));
                    if (rd_en) rd_cnt++;
                    if (rd_en && rd_addr == 6'd32) rd32_cnt++;
                    if (clear) clear_cyc = cyc;
                    case (sc)
                        6'd1:  chk("spot_addr_k1", 32'(rd_addr), 24);
                        6'd10: chk("spot_addr_k10", 32'(rd_addr), 32);
                        6'd20: chk("spot_addr_k20", 32'(rd_addr), 42);
                        6'd26: chk("spot_addr_k26", 32'(rd_addr), 47);
                        6'd38: chk("spot_addr_k38", 32'(rd_addr), 0);
                        6'd44: chk("spot_addr_k44", 32'(rd_addr), 5);
                        6'd56: chk("spot_addr_k56", 32'(rd_addr), 17);
                        6'd63: chk("spot_addr_k63", 32'(rd_addr), 23);
                        default: ;
                    endcase
                end
            end else begin
                chk("idle_rd_en", 32'(rd_en), 0);
                chk("idle_clear", 32'(clear), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int dcyc;
        r = 0;
        for (int k = 0; k < 64; k++) addr_tab[k] = 0;
        for (int f = -26; f <= 26; f++) begin
            if (f != 0 && f != 7 && f != -7 && f != 21 && f != -21) begin
                addr_tab[(f < 0) ? f + 64 : f] = r;
                r++;
            end
        end

        rst_n = 1'b0; start = 1'b0; num_symbols = '0; full = 1'b1; rdy = 1'b1;
        #23;
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // One symbol, no backpressure.
        beats = 0; rd_cnt = 0;
        push_frame(1);
        start_frame(1);
        chk("busy_after_start", 32'(busy), 1);
        wait_done("t1", dcyc);
        chk("t1_beats", 32'(beats), 64);
        chk("t1_reads", 32'(rd_cnt), 48);
        after_done("t1", dcyc);

        // Five symbols: pilot polarity flips on symbol 4.
        beats = 0; rd_cnt = 0;
        push_frame(5);
        start_frame(5);
        wait_done("t2", dcyc);
        chk("t2_beats", 32'(beats), 320);
        chk("t2_reads", 32'(rd_cnt), 240);
        after_done("t2", dcyc);

        // Three-cycle stall at k=10.
        beats = 0; rd32_cnt = 0;
        push_frame(1);
        start_frame(1);
        wait_beat(10, 0, "t3_k10");
        rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t3_sc_held", 32'(sc), 10);
        rdy = 1'b1;
        wait_done("t3", dcyc);
        chk("t3_addr32_reads", 32'(rd32_cnt), 1);
        chk("t3_beats", 32'(beats), 64);
        after_done("t3", dcyc);

        // Interleaver not full between symbols 0 and 1.
        push_frame(2);
        start_frame(2);
        wait_beat(63, 0, "t4_k63");
        full = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("t4_waitfull_val", 32'(val), 0);
        end
        chk("t4_waitfull_busy", 32'(busy), 1);
        full = 1'b1;
        @(posedge clk); #1;
        chk("t4_resume_val", 32'(val), 1);
        chk("t4_resume_symcnt", 32'(symcnt), 1);
        wait_done("t4", dcyc);
        after_done("t4", dcyc);

        // Zero-length frame.
        beats = 0; rd_cnt = 0;
        start_frame(0);
        wait_done("t5a", dcyc);
        repeat (2) @(posedge clk);
        #1;
        chk("t5a_beats", 32'(beats), 0);
        chk("t5a_reads", 32'(rd_cnt), 0);
        chk("t5a_busy", 32'(busy), 0);

        // Second start while busy must not change the frame length.
        beats = 0;
        push_frame(2);
        start_frame(2);
        repeat (5) @(posedge clk);
        start_frame(1);
        wait_done("t5b", dcyc);
        chk("t5b_beats", 32'(beats), 128);
        after_done("t5b", dcyc);

        // Asynchronous reset at k=30 of symbol 2, then a fresh frame.
        push_frame(4);
        start_frame(4);
        wait_beat(30, 2, "t6_k30");
        rst_n = 1'b0;
        #1;
        check_reset_vals("t6_abort");
        exp_q.delete();
        #2;
        rst_n = 1'b1;
        beats = 0;
        push_frame(1);
        start_frame(1);
        wait_done("t6", dcyc);
        chk("t6_beats", 32'(beats), 64);
        after_done("t6", dcyc);

        chk("queue_empty_end", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ofdm_symbol_scheduler.md
Name: ofdm_symbol_scheduler

Overview:
Sequences the per-OFDM-symbol subcarrier emission stage of the 802.11a transmit path. For each of 64 IFFT bins it decides null, pilot or data, issues reads to the interleaver, drives mapper/pilot-insertion controls, and hands a stream to the IFFT under valid/ready backpressure. It counts symbols, advances the 127-length pilot polarity scrambler once per symbol, and clears the interleaver at each symbol end.

Parameters:
SYM_W, 12, width of symbol count and num_symbols
PILOT_SEED, 7'h7F, pilot scrambler initial state

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin a frame; ignored while busy
num_symbols  in  SYM_W  total symbols including SIGNAL; latched on accepted start
full_intlver  in  1  interleaver holds one complete symbol (48 coded points)
clear_intlver  out  1  one-cycle pulse; interleaver drained
rd_en_intlver  out  1  interleaver read strobe
rd_addr_intlver  out  6  interleaver read address, 0..47
ostream_val  out  1  subcarrier valid to IFFT/mapper
ostream_rdy  in  1  downstream accepts
sc_index  out  6  current IFFT bin k, 0..63
is_zero  out  1  bin is null
is_pilot  out  1  bin is pilot
pilot_indicator  out  1  1 = +1, 0 = -1; meaningful only when is_pilot
symbol_cnt  out  SYM_W  index of current symbol
busy  out  1  high from accepted start until done
done  out  1  one-cycle end-of-frame pulse

Behaviour:
- Reset (reset=0, async): state IDLE, sc_index=0, symbol_cnt=0, scrambler=PILOT_SEED; all outputs 0 except pilot_indicator=1.
- FSM: IDLE -> WAIT_FULL on start (num_symbols!=0); IDLE -> DONE on start with num_symbols==0. WAIT_FULL -> STREAM when full_intlver=1 (ostream_val high next cycle). STREAM: fire = ostream_val && ostream_rdy; each fire increments sc_index. Fire at k=63: sc_index wraps to 0, clear_intlver pulses that cycle, scrambler advances, symbol_cnt+1; next state DONE if symbol_cnt+1==num_symbols, else WAIT_FULL. DONE: done=1 for one cycle -> IDLE, symbol_cnt cleared.
- ostream_val=1 only in STREAM. sc_index, is_zero, is_pilot, pilot_indicator, rd_addr_intlver are combinational from sc_index/state and stay stable while stalled.
- Null bins: 0, 27..37. Pilot bins: 7, 21, 43, 57.
- rd_en_intlver = fire && !is_zero && !is_pilot; never asserted during a stall. Exactly 48 reads per symbol.
- Address map: k 1..6 -> k+23; 8..20 -> k+22; 22..26 -> k+21; 38..42 -> k-38; 44..56 -> k-39; 58..63 -> k-40. Outside data bins the address is 0.
- Pilot scrambler: x^7+x^4+1. polarity bit p = s[6]^s[3]; advance s <= {s[5:0], p}. p=0 means +1. Base pilot values: bins 7, 43, 57 = +1; bin 21 = -1. pilot_indicator = ~(p ^ (k==21)).
- Scrambler resets to PILOT_SEED on accepted start, so symbol 0 (SIGNAL) uses p0.
- Scrambler period is 127 symbols. It wraps naturally. symbol_cnt wraps modulo 2^SYM_W; the termination compare still uses the latched num_symbols.
- If full_intlver drops mid-STREAM, it is ignored. full_intlver is sampled only in WAIT_FULL.
- Reset asserted mid-STREAM aborts immediately: no clear_intlver pulse and no done pulse.

Optional Feature:
SCHED_STALL_CNT_EN: when defined, adds output stall_cycles (16 bits). It counts cycles with ostream_val && !ostream_rdy, saturates at 16'hFFFF, clears on accepted start and on reset. When undefined, the port and counter are absent.

Test Plan:
- num_symbols=1, ostream_rdy=1, full_intlver=1: exactly 64 valid beats. rd_en pulses 48 times. At k=1 addr=24, k=38 addr=0, k=44 addr=5, k=63 addr=23. clear_intlver on the k=63 beat. done 1 cycle later. busy low after done.
- num_symbols=5: bin-21 pilot_indicator=0 for symbols 0..3 and 1 for symbol 4. Bins 7, 43, 57 show the inverse.
- Drop ostream_rdy for 3 cycles at k=10: sc_index held at 10 and rd_en low during the stall. Exactly one rd_en with addr=32 on release.
- full_intlver low for 20 cycles between symbols 0 and 1: FSM stays in WAIT_FULL with ostream_val=0. Streaming resumes 1 cycle after full_intlver rises.
- num_symbols=0 on start: done pulses with no ostream_val and no rd_en. Second start while busy: ignored, and the frame length is unchanged.
- Assert reset at k=30 of symbol 2: all outputs return to reset values asynchronously. A fresh start replays symbol 0 with pilot polarity p0.
